// File: rtl/reaction_fsm.sv
// reaction_fsm: controller for a reaction-time tester.
//   A start_btn pulse arms a trial and enables the external random-wait
//   counter. When that counter reports rwait_done, the lamp lights and
//   milliseconds are counted until react_btn. Pressing before the lamp
//   gives EARLY. No press within MAX_MS gives TIMEOUT.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   start_btn    single-cycle pulse, begins or restarts a trial
//   react_btn    single-cycle pulse, user response
//   rwait_done   random wait expired (honoured only while waiting)
//   start_rwait  level, high only while waiting for the random delay
//   led          stimulus lamp, high only while timing
//   rtime[13:0]  reaction time in ms
//   rtime_valid  rtime holds a completed measurement
//   early        user pressed before the lamp lit
//   timeout      no response within MAX_MS
// All outputs are registered. They are derived from the next state, so each
// output is valid on the same edge on which its state is entered.
module reaction_fsm #(
  parameter int CLKS_PER_MS = 100000,
  parameter int MAX_MS      = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        react_btn,
  input  logic        rwait_done,
  output logic        start_rwait,
  output logic        led,
  output logic [13:0] rtime,
  output logic        rtime_valid,
  output logic        early,
  output logic        timeout
);

  localparam int TW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_MS - 1);
  localparam logic [13:0]   RT_MAX    = 14'(MAX_MS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RWAIT   = 3'd1;
  localparam logic [2:0] S_TIMING  = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_EARLY   = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [13:0]   rtime_nxt;

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    rtime_nxt = rtime;
    case (state)
      S_IDLE: begin
        if (start_btn) begin
          state_nxt = S_RWAIT;
          rtime_nxt = '0;
        end
      end
      S_RWAIT: begin
        // A press wins over a simultaneous rwait_done.
        if (react_btn) begin
          state_nxt = S_EARLY;
          rtime_nxt = '0;
        end else if (rwait_done) begin
          state_nxt = S_TIMING;
          tick_nxt  = '0;
          rtime_nxt = '0;
        end
      end
      S_TIMING: begin
        // A press freezes rtime at its current value, even on a wrap cycle,
        // so a press coincident with the final wrap reports MAX_MS.
        if (react_btn) begin
          state_nxt = S_DONE;
        end else if (tick == TICK_LAST) begin
          tick_nxt = '0;
          if (rtime == RT_MAX) begin
            state_nxt = S_TIMEOUT;
            rtime_nxt = RT_MAX;
          end else begin
            rtime_nxt = rtime + 14'd1;
          end
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      S_DONE, S_EARLY, S_TIMEOUT: begin
        if (start_btn) begin
          state_nxt = S_RWAIT;
          tick_nxt  = '0;
          rtime_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tick_nxt  = '0;
        rtime_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      tick        <= '0;
      rtime       <= '0;
      start_rwait <= 1'b0;
      led         <= 1'b0;
      rtime_valid <= 1'b0;
      early       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick        <= tick_nxt;
      rtime       <= rtime_nxt;
      start_rwait <= (state_nxt == S_RWAIT);
      led         <= (state_nxt == S_TIMING);
      rtime_valid <= (state_nxt == S_DONE);
      early       <= (state_nxt == S_EARLY);
      timeout     <= (state_nxt == S_TIMEOUT);
    end
  end

endmodule
